mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32: address/data width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 i_if_req  input  1  fetch request; held with i_if_addr until o_if_gnt.
REQ-005 i_if_addr  input  XLEN  fetch address.
REQ-006 o_if_gnt  output  1  one-cycle pulse: fetch complete.
REQ-007 o_if_rdata  output  XLEN  fetch data; valid only with o_if_gnt.
REQ-008 i_dm_req  input  1  data request; held with payload until o_dm_gnt.
REQ-009 i_dm_we  input  1  data write (1) / read (0).
REQ-010 i_dm_addr, i_dm_wdata  input  XLEN each  data address, write data.
REQ-011 o_dm_gnt  output  1  one-cycle pulse: data access complete.
REQ-012 o_dm_rdata  output  XLEN  read data; valid only with o_dm_gnt.
REQ-013 o_mem_valid  output  1  unified-bus request valid.
REQ-014 i_mem_ready  input  1  memory accepts request when high with o_mem_valid.
REQ-015 o_mem_addr, o_mem_wdata  output  XLEN each; o_mem_we  output  1.
REQ-016 i_mem_rvalid  input  1  response/ack, one per accepted request, reads and writes.
REQ-017 i_mem_rdata  input  XLEN  response data.
REQ-018 o_busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT; one outstanding transaction maximum.
REQ-020 IDLE: if any request, select owner, latch owner's addr/we/wdata into registers (fetch: we=0, wdata=0), go ISSUE; else stay.
REQ-021 Fixed priority (macro absent): data wins over fetch when both requested in the same IDLE cycle.
REQ-022 ISSUE: o_mem_valid=1 with latched payload; payload stable while i_mem_ready=0; on i_mem_ready=1 go WAIT.
REQ-023 WAIT: o_mem_valid=0; on i_mem_rvalid=1 pulse owner's gnt that cycle, drive i_mem_rdata on owner's rdata combinationally, go IDLE.
REQ-024 Minimum latency: request seen IDLE cycle 0, o_mem_valid cycle 1, gnt cycle 2 (ready and rvalid immediate); back-to-back transactions 3 cycles apart.
REQ-025 Requester still holding req in IDLE after its gnt starts a new transaction.
REQ-026 Non-owner's gnt=0 and rdata=0 at all times; both rdata=0 when no gnt.
REQ-027 i_mem_rvalid in IDLE or ISSUE is ignored (protocol violation; no gnt, no state change).
REQ-028 Request arriving mid-transaction waits; never preempts owner.

Reset
REQ-029 rstn low: state=IDLE, owner=fetch, latched payload=0, last-served=fetch; o_mem_valid, o_mem_we, o_if_gnt, o_dm_gnt, o_busy=0; all data outputs 0.
REQ-030 Reset mid-transaction abandons it; stale i_mem_rvalid after release is ignored per REQ-027.

Configuration
REQ-031 Macro MEM_ARBITER_RR_EN defined: round-robin; on simultaneous requests grant the requester not last served; last-served register updates on each gnt; reset value fetch, so data wins first tie.
REQ-032 Macro undefined: fixed priority per REQ-021; no last-served register.

Structure
REQ-033 Shared core package holds state enum (IDLE/ISSUE/WAIT) and owner enum (OWN_IF/OWN_DM).
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 Fetch only, addr 0x0000_0010, ready/rvalid immediate, rdata 0x0000_0013 -> o_mem_valid cycle 1, o_if_gnt cycle 2 with rdata 0x0000_0013.
REQ-036 Both request cycle 0 (dm write 0x100 <- 0xDEAD_BEEF), fixed priority -> first bus transaction we=1 addr 0x100 wdata 0xDEAD_BEEF, dm_gnt; fetch granted next transaction.
REQ-037 ready held low 4 cycles in ISSUE -> o_mem_valid and payload stable all 4 cycles, WAIT entered cycle after ready.
REQ-038 MEM_ARBITER_RR_EN, both requesting continuously 4 transactions -> grant order DM, IF, DM, IF.
REQ-039 rstn low in WAIT, then rvalid pulse after release -> all outputs 0, no gnt, state IDLE.
REQ-040 rvalid pulse in IDLE with no requests -> no gnt, o_busy stays 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state and bus owner.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and unified memory bus signals of mem_arbiter.
// slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if #(parameter int XLEN = 32);
  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic            o_if_gnt;
  logic [XLEN-1:0] o_if_rdata;

  logic            i_dm_req;
  logic            i_dm_we;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wdata;
  logic            o_dm_gnt;
  logic [XLEN-1:0] o_dm_rdata;

  logic            o_mem_valid;
  logic            i_mem_ready;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic            o_mem_we;
  logic            i_mem_rvalid;
  logic [XLEN-1:0] i_mem_rdata;

  logic            o_busy;

  modport slave (
    input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
           i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_if_gnt, o_if_rdata, o_dm_gnt, o_dm_rdata,
           o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_we, o_busy
  );

  modport master (
    output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
           i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_if_gnt, o_if_rdata, o_dm_gnt, o_dm_rdata,
           o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_we, o_busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory bus, one transaction in flight.
// MEM_ARBITER_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rstn,
  mem_arbiter_if.slave   bus
);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [XLEN-1:0] addr_q,  addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q,    we_d;
  owner_e          pick;

  logic            mem_valid, if_gnt, dm_gnt;
  logic [XLEN-1:0] mem_addr, mem_wdata, if_rdata, dm_rdata;
  logic            mem_we;

`ifdef MEM_ARBITER_RR_EN
  owner_e last_q, last_d;

  // On a tie, hand the bus to whichever side was not served last.
  always_comb begin
    if (bus.i_dm_req && bus.i_if_req) pick = (last_q == OWN_DM) ? OWN_IF : OWN_DM;
    else                              pick = bus.i_dm_req ? OWN_DM : OWN_IF;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_q <= OWN_IF;
    else       last_q <= last_d;
  end
`else
  always_comb pick = bus.i_dm_req ? OWN_DM : OWN_IF;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
`ifdef MEM_ARBITER_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_dm_req || bus.i_if_req) begin
          owner_d = pick;
          state_d = ISSUE;
          if (pick == OWN_DM) begin
            addr_d  = bus.i_dm_addr;
            wdata_d = bus.i_dm_wdata;
            we_d    = bus.i_dm_we;
          end else begin
            addr_d  = bus.i_if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
        end
      end
      ISSUE: begin
        mem_valid = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = we_q;
        if (bus.i_mem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.i_mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_DM) begin
            dm_gnt   = 1'b1;
            dm_rdata = bus.i_mem_rdata;
          end else begin
            if_gnt   = 1'b1;
            if_rdata = bus.i_mem_rdata;
          end
`ifdef MEM_ARBITER_RR_EN
          last_d = owner_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign bus.o_mem_valid = mem_valid;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_if_rdata  = if_rdata;
  assign bus.o_dm_gnt    = dm_gnt;
  assign bus.o_dm_rdata  = dm_rdata;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations. Honours MEM_ARBITER_RR_EN.
module tb_mem_arbiter;
  localparam int XLEN = 32;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dreq_t;
  typedef struct { int cyc; logic dm; logic [31:0] rdata; } gev_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } bev_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) bus();
  mem_arbiter #(.XLEN(XLEN)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int tests = 0, fails = 0, cyc = 0;

  // requester side
  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic [31:0] if_q[$];
  dreq_t       dm_q[$];
  logic        if_gnt_seen = 0, dm_gnt_seen = 0;

  // memory side: automatic responder or manual stimulus
  logic        auto_rsp = 1;
  int          ready_lat = 0, resp_lat = 0;
  logic        a_ready = 0, a_rvalid = 0, m_ready = 0, m_rvalid = 0;
  logic [31:0] a_rdata = 0, m_rdata = 0;
  logic [31:0] mem [logic [31:0]];

  gev_t glog[$];
  bev_t acc_log[$];
  int   rise_log[$];

  assign bus.i_if_req     = if_req;
  assign bus.i_if_addr    = if_addr;
  assign bus.i_dm_req     = dm_req;
  assign bus.i_dm_we      = dm_we;
  assign bus.i_dm_addr    = dm_addr;
  assign bus.i_dm_wdata   = dm_wdata;
  assign bus.i_mem_ready  = auto_rsp ? a_ready  : m_ready;
  assign bus.i_mem_rvalid = auto_rsp ? a_rvalid : m_rvalid;
  assign bus.i_mem_rdata  = auto_rsp ? a_rdata  : m_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requesters: hold until granted, then immediately present the next queued request.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        if_req = 0; dm_req = 0;
        if_q.delete(); dm_q.delete();
      end else begin
        if (if_gnt_seen) if_req = 0;
        if (dm_gnt_seen) dm_req = 0;
        if (!if_req && if_q.size() > 0) begin
          if_addr = if_q.pop_front(); if_req = 1;
        end
        if (!dm_req && dm_q.size() > 0) begin
          dreq_t r;
          r = dm_q.pop_front();
          dm_we = r.we; dm_addr = r.addr; dm_wdata = r.wdata; dm_req = 1;
        end
      end
    end
  end

  // Memory: ready after ready_lat valid cycles, response resp_lat cycles after acceptance.
  initial begin
    logic lastv, lastr, l_we, pend;
    logic [31:0] l_addr, l_wdata, rd;
    int hold, pcnt;
    lastv = 0; lastr = 0; l_we = 0; pend = 0; l_addr = 0; l_wdata = 0; rd = 0;
    hold = 0; pcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstn || !auto_rsp) begin
        pend = 0; hold = 0; lastv = 0; lastr = 0;
        a_ready = 0; a_rvalid = 0; a_rdata = 0;
      end else begin
        if (lastv && lastr) begin
          pend = 1; pcnt = 0; hold = 0;
          if (l_we) begin mem[l_addr] = l_wdata; rd = 32'h0; end
          else rd = mem.exists(l_addr) ? mem[l_addr] : (l_addr ^ 32'hA5A5_0000);
        end
        a_rvalid = 0; a_rdata = 0;
        if (pend) begin
          if (pcnt == resp_lat) begin a_rvalid = 1; a_rdata = rd; pend = 0; end
          else pcnt++;
        end
        a_ready = 0;
        if (bus.o_mem_valid) begin a_ready = (hold >= ready_lat); hold++; end
        lastv = bus.o_mem_valid; lastr = a_ready;
        l_addr = bus.o_mem_addr; l_we = bus.o_mem_we; l_wdata = bus.o_mem_wdata;
      end
    end
  end

  // Transaction model: at most one job; it is either waiting for acceptance or for its response.
  initial begin
    logic m_act, m_acc, m_own, m_we, m_last, e_valid, e_gnt, prev_valid;
    logic [31:0] m_addr, m_wdata;
    m_act = 0; m_acc = 0; m_own = 0; m_we = 0; m_last = 0; prev_valid = 0;
    m_addr = 0; m_wdata = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_act = 0; m_acc = 0; m_own = 0; m_we = 0; m_last = 0; m_addr = 0; m_wdata = 0;
      end
      e_valid = m_act && !m_acc;
      e_gnt   = m_act && m_acc && bus.i_mem_rvalid;
      chk("busy",      bus.o_busy,      m_act);
      chk("mem_valid", bus.o_mem_valid, e_valid);
      chk("mem_addr",  bus.o_mem_addr,  e_valid ? m_addr : 32'h0);
      chk("mem_we",    bus.o_mem_we,    e_valid && m_we);
      chk("mem_wdata", bus.o_mem_wdata, e_valid ? m_wdata : 32'h0);
      chk("if_gnt",    bus.o_if_gnt,    e_gnt && !m_own);
      chk("dm_gnt",    bus.o_dm_gnt,    e_gnt && m_own);
      chk("if_rdata",  bus.o_if_rdata,  (e_gnt && !m_own) ? bus.i_mem_rdata : 32'h0);
      chk("dm_rdata",  bus.o_dm_rdata,  (e_gnt && m_own)  ? bus.i_mem_rdata : 32'h0);

      if_gnt_seen = bus.o_if_gnt;
      dm_gnt_seen = bus.o_dm_gnt;
      if (bus.o_if_gnt) glog.push_back('{cyc, 1'b0, bus.o_if_rdata});
      if (bus.o_dm_gnt) glog.push_back('{cyc, 1'b1, bus.o_dm_rdata});
      if (bus.o_mem_valid && !prev_valid) rise_log.push_back(cyc);
      if (bus.o_mem_valid && bus.i_mem_ready)
        acc_log.push_back('{cyc, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata});
      prev_valid = bus.o_mem_valid;

      if (rstn) begin
        if (!m_act) begin
          if (bus.i_if_req || bus.i_dm_req) begin
`ifdef MEM_ARBITER_RR_EN
            m_own = (bus.i_if_req && bus.i_dm_req) ? !m_last : bus.i_dm_req;
`else
            m_own = bus.i_dm_req;
`endif
            m_act = 1; m_acc = 0;
            m_addr  = m_own ? bus.i_dm_addr  : bus.i_if_addr;
            m_we    = m_own ? bus.i_dm_we    : 1'b0;
            m_wdata = m_own ? bus.i_dm_wdata : 32'h0;
          end
        end else if (!m_acc) begin
          if (bus.i_mem_ready) m_acc = 1;
        end else if (bus.i_mem_rvalid) begin
          m_act = 0; m_last = m_own;
        end
      end
      cyc++;
    end
  end

  task automatic sync();
    @(posedge clk); #3;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((if_q.size() > 0 || dm_q.size() > 0 || if_req || dm_req || bus.o_busy) && n < 300);
    chk({nm, "_done"}, n < 300, 1'b1);
  endtask

  task automatic wait_state(input logic want_valid, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.o_busy && bus.o_mem_valid == want_valid) && n < 100);
    chk({nm, "_reach"}, n < 100, 1'b1);
  endtask

  task automatic do_reset();
    sync(); rstn = 0;
    sync(); sync();
    rstn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, a0, r0;
    // Reset with a response pulse present: nothing may leak out.
    auto_rsp = 0; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF; m_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_busy",   bus.o_busy, 1'b0);
    chk("rst_valid",  bus.o_mem_valid, 1'b0);
    chk("rst_dmgnt",  bus.o_dm_gnt, 1'b0);
    chk("rst_ifrd",   bus.o_if_rdata, 32'h0);
    sync(); m_rvalid = 0; m_ready = 0; m_rdata = 0; auto_rsp = 1;
    rstn = 1;
    sync();

    // Single fetch, minimum latency.
    mem[32'h10] = 32'h0000_0013;
    ready_lat = 0; resp_lat = 0;
    g0 = glog.size(); r0 = rise_log.size();
    if_q.push_back(32'h10);
    wait_done("fetch");
    chk("fetch_gnt_lat",   glog[g0].cyc - rise_log[r0], 1);
    chk("fetch_owner",     glog[g0].dm, 1'b0);
    chk("fetch_rdata",     glog[g0].rdata, 32'h0000_0013);

    // Simultaneous data write and fetch: data first, fetch 3 cycles later sees the write.
    sync();
    g0 = glog.size(); a0 = acc_log.size();
    dm_q.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF});
    if_q.push_back(32'h100);
    wait_done("tie");
    chk("tie_we",     acc_log[a0].we, 1'b1);
    chk("tie_addr",   acc_log[a0].addr, 32'h100);
    chk("tie_wdata",  acc_log[a0].wdata, 32'hDEAD_BEEF);
    chk("tie_first",  glog[g0].dm, 1'b1);
    chk("tie_second", glog[g0+1].dm, 1'b0);
    chk("tie_rdata",  glog[g0+1].rdata, 32'hDEAD_BEEF);
    chk("tie_gap",    glog[g0+1].cyc - glog[g0].cyc, 3);

    // Memory stalls ready for 4 cycles.
    sync();
    ready_lat = 4;
    g0 = glog.size(); a0 = acc_log.size(); r0 = rise_log.size();
    dm_q.push_back('{1'b0, 32'h10, 32'h0});
    wait_done("stall");
    chk("stall_len",   acc_log[a0].cyc - rise_log[r0], 4);
    chk("stall_wait",  glog[g0].cyc - acc_log[a0].cyc, 1);
    chk("stall_rdata", glog[g0].rdata, 32'h0000_0013);

    // Write then later fetch of same address with slower memory.
    sync();
    ready_lat = 1; resp_lat = 2;
    g0 = glog.size();
    dm_q.push_back('{1'b1, 32'h200, 32'h0000_0011});
    sync();
    if_q.push_back(32'h200);
    wait_done("slow");
    chk("slow_first", glog[g0].dm, 1'b1);
    chk("slow_rdata", glog[g0+1].rdata, 32'h0000_0011);

    // Both sides requesting continuously for 4 transactions, from a fresh reset.
    do_reset();
    ready_lat = 0; resp_lat = 1;
    sync();
    g0 = glog.size();
    dm_q.push_back('{1'b0, 32'h300, 32'h0});
    dm_q.push_back('{1'b0, 32'h304, 32'h0});
    if_q.push_back(32'h400);
    if_q.push_back(32'h404);
    wait_done("order");
`ifdef MEM_ARBITER_RR_EN
    chk("order0", glog[g0].dm,   1'b1);
    chk("order1", glog[g0+1].dm, 1'b0);
    chk("order2", glog[g0+2].dm, 1'b1);
    chk("order3", glog[g0+3].dm, 1'b0);
`else
    chk("order0", glog[g0].dm,   1'b1);
    chk("order1", glog[g0+1].dm, 1'b1);
    chk("order2", glog[g0+2].dm, 1'b0);
    chk("order3", glog[g0+3].dm, 1'b0);
`endif
    chk("order_ifrd", glog[g0+3].rdata, 32'hA5A5_0404);

    // Response pulse while still in ISSUE must be ignored.
    sync();
    auto_rsp = 0; m_ready = 0; m_rvalid = 0;
    g0 = glog.size();
    dm_q.push_back('{1'b0, 32'h10, 32'h0});
    wait_state(1'b1, "issue");
    sync(); m_rvalid = 1; m_rdata = 32'h77;
    sync(); m_rvalid = 0; m_rdata = 0; m_ready = 1;
    sync(); m_ready = 0; m_rvalid = 1; m_rdata = 32'h55;
    sync(); m_rvalid = 0; m_rdata = 0;
    wait_done("early_rv");
    chk("early_cnt",   glog.size() - g0, 1);
    chk("early_rdata", glog[g0].rdata, 32'h55);

    // Reset while waiting for a response, then a stale response after release.
    sync();
    m_ready = 1;
    g0 = glog.size();
    dm_q.push_back('{1'b0, 32'h10, 32'h0});
    wait_state(1'b0, "wait");
    do_reset();
    m_ready = 0;
    sync(); m_rvalid = 1; m_rdata = 32'h0BAD;
    @(negedge clk);
    chk("stale_busy",  bus.o_busy, 1'b0);
    chk("stale_dmgnt", bus.o_dm_gnt, 1'b0);
    chk("stale_dmrd",  bus.o_dm_rdata, 32'h0);
    sync(); m_rvalid = 0; m_rdata = 0;
    @(negedge clk);
    chk("stale_cnt", glog.size() - g0, 0);

    // Response pulse in IDLE with no requests.
    sync(); m_rvalid = 1; m_rdata = 32'h1234;
    @(negedge clk);
    chk("idle_rv_busy",  bus.o_busy, 1'b0);
    chk("idle_rv_ifgnt", bus.o_if_gnt, 1'b0);
    sync(); m_rvalid = 0; m_rdata = 0;
    @(negedge clk);
    chk("idle_rv_busy2", bus.o_busy, 1'b0);
    chk("idle_rv_cnt",   glog.size() - g0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
